mult_req_sched: RTL and testbench

Round-robin scheduler that shares the 16x16 multiplier/64-entry product-memory block among NUM_REQ operand requesters.
- Fill phase: grants one operand pair per cycle and drives EN_mult/mult_input0/1. It records which requester owns each of the 64 memory slots.
- Drain phase: once the block is full, pulses EN_blockRead and forwards each VALID_memVal beat to the consumers, tagged with the owning requester id.

---
 rtl/mult_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mult_req_sched.sv | 110 +++++++++++
 tb/tb_mult_req_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier block and its request scheduler.
package mult_pkg;

  localparam int MULT_DEPTH  = 64;
  localparam int MULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_FULL,
    DRAIN
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr wins, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  localparam int unsigned N = NUM_REQ;

  always_comb begin
    int unsigned idx;
    logic        hit;
    grant    = '0;
    grant_id = '0;
    hit      = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        grant_id   = ID_W'(idx);
        grant[idx] = en;
      end
    end
  end

endmodule

// File: rtl/mult_req_sched.sv
// Shares one 16x16 multiplier / product-memory block among NUM_REQ operand requesters,
// remembering which requester owns each slot so drained products can be tagged.
module mult_req_sched
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3,
  parameter int DEPTH   = MULT_DEPTH,
  parameter int DATA_W  = MULT_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op0,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  output logic                      EN_mult,
  output logic [DATA_W-1:0]         mult_input0,
  output logic [DATA_W-1:0]         mult_input1,
  input  logic                      RDY_mult,
  output logic                      EN_blockRead,
  input  logic                      VALID_memVal,
  input  logic [DATA_W-1:0]         memVal_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int               AW    = $clog2(DEPTH);
  localparam int               CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [ID_W-1:0]  LAST  = ID_W'(NUM_REQ - 1);

  sched_state_t         state;
  logic [CNT_W-1:0]     issue_cnt;
  logic [CNT_W-1:0]     drain_cnt;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_id;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic                 xfer;
  logic [ID_W-1:0]      tag [DEPTH];

  assign accept = RDY_mult && (issue_cnt < FULL) && (state == IDLE || state == FILL);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .en      (accept),
    .grant   (grant),
    .grant_id(grant_id)
  );

  // grant bits are only ever set on a valid requester, so any grant is a transfer
  assign req_ready    = grant;
  assign xfer         = |grant;
  assign EN_blockRead = (state == WAIT_FULL) && !RDY_mult;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      drain_cnt   <= '0;
      rr_ptr      <= '0;
      EN_mult     <= 1'b0;
      mult_input0 <= '0;
      mult_input1 <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
    end else begin
      EN_mult   <= xfer;
      rsp_valid <= 1'b0;
      if (xfer) begin
        mult_input0 <= req_op0[grant_id*DATA_W +: DATA_W];
        mult_input1 <= req_op1[grant_id*DATA_W +: DATA_W];
        issue_cnt   <= issue_cnt + 1'b1;
        rr_ptr      <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
      end
      case (state)
        IDLE:      if (|req_valid) state <= FILL;
        FILL:      if (issue_cnt == FULL) state <= WAIT_FULL;
        WAIT_FULL: if (!RDY_mult) state <= DRAIN;
        DRAIN: begin
          if (drain_cnt == FULL) begin
            state     <= IDLE;
            issue_cnt <= '0;
            drain_cnt <= '0;
          end else if (VALID_memVal) begin
            rsp_valid <= 1'b1;
            rsp_data  <= memVal_data;
            rsp_id    <= tag[drain_cnt[AW-1:0]];
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) tag[issue_cnt[AW-1:0]] <= grant_id;
  end

endmodule

// File: tb/tb_mult_req_sched.sv
// Self-checking bench for mult_req_sched with a behavioural scheduler model and response scoreboard.
module tb_mult_req_sched;
  import mult_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 3;
  localparam int DEP = 64;
  localparam int DW  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_op0;
  logic [N*DW-1:0] req_op1;
  logic            EN_mult;
  logic [DW-1:0]   mult_input0;
  logic [DW-1:0]   mult_input1;
  logic            RDY_mult;
  logic            EN_blockRead;
  logic            VALID_memVal;
  logic [DW-1:0]   memVal_data;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  always #5 clk = ~clk;

  mult_req_sched #(
    .NUM_REQ(N),
    .ID_W   (IDW),
    .DEPTH  (DEP),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op0     (req_op0),
    .req_op1     (req_op1),
    .EN_mult     (EN_mult),
    .mult_input0 (mult_input0),
    .mult_input1 (mult_input1),
    .RDY_mult    (RDY_mult),
    .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal),
    .memVal_data (memVal_data),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } rsp_t;

  typedef struct {
    logic [N-1:0] rv;
    logic         rdy;
    logic [N-1:0] exp_ready;
  } vec_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [31:0]  src_q [N][$];
  logic [N-1:0] src_en;
  logic         rdy_cfg, spur_en, drain_go;
  logic [DW-1:0] prod_q [$];
  rsp_t         exp_rsp [$];
  sched_state_t m_state;
  int           m_issue, m_drain, m_rr;
  logic         exp_en, exp_rv;
  logic [DW-1:0] exp_in0, exp_in1;
  rsp_t         exp_r;
  int           cyc = 0;
  int           blk_pulses, rsp_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE;
    m_issue = 0;
    m_drain = 0;
    m_rr    = 0;
    exp_en  = 1'b0;
    exp_rv  = 1'b0;
    exp_rsp.delete();
    prod_q.delete();
    drain_go = 1'b0;
  endtask

  task automatic step();
    logic         acc;
    int           w, old_issue, old_drain;
    logic [N-1:0] er;
    logic [31:0]  pr;
    logic [DW-1:0] pp;
    rsp_t         t;
    @(posedge clk);
    #1;
    cyc++;
    chk("EN_mult", EN_mult, exp_en);
    if (exp_en) begin
      chk("mult_input0", mult_input0, exp_in0);
      chk("mult_input1", mult_input1, exp_in1);
    end
    if (EN_mult) begin
      pp = mult_input0 * mult_input1;
      prod_q.push_back(pp);
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      chk("rsp_id", rsp_id, exp_r.id);
      chk("rsp_data", rsp_data, exp_r.data);
    end
    if (rsp_valid) rsp_seen++;
    chk("busy", busy, m_state != IDLE);

    for (int i = 0; i < N; i++) begin
      req_valid[i] = src_en[i] && (src_q[i].size() > 0);
      if (req_valid[i]) begin
        req_op0[i*DW +: DW] = src_q[i][0][31:16];
        req_op1[i*DW +: DW] = src_q[i][0][15:0];
      end else begin
        req_op0[i*DW +: DW] = '0;
        req_op1[i*DW +: DW] = '0;
      end
    end
    RDY_mult = rdy_cfg;
    if (drain_go && prod_q.size() > 0 && (cyc % 4) != 3) begin
      VALID_memVal = 1'b1;
      memVal_data  = prod_q.pop_front();
      if (prod_q.size() == 0) drain_go = 1'b0;
    end else if (spur_en && !drain_go) begin
      VALID_memVal = 1'b1;
      memVal_data  = 16'hdead;
    end else begin
      VALID_memVal = 1'b0;
      memVal_data  = '0;
    end
    #1;

    old_issue = m_issue;
    old_drain = m_drain;
    acc = RDY_mult && (m_issue < DEP) && (m_state == IDLE || m_state == FILL);
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
    end
    er = (acc && w >= 0) ? N'(1 << w) : '0;
    chk("req_ready", req_ready, er);
    chk("EN_blockRead", EN_blockRead, (m_state == WAIT_FULL) && !RDY_mult);
    if (EN_blockRead) begin
      blk_pulses++;
      drain_go = 1'b1;
    end

    exp_en = acc && (w >= 0);
    exp_rv = 1'b0;
    if (exp_en) begin
      pr = src_q[w].pop_front();
      exp_in0 = pr[31:16];
      exp_in1 = pr[15:0];
      t.id   = IDW'(w);
      t.data = pr[31:16] * pr[15:0];
      exp_rsp.push_back(t);
      m_issue++;
      m_rr = (w + 1) % N;
    end
    if (m_state == DRAIN && VALID_memVal && old_drain < DEP) begin
      n_checks++;
      if (exp_rsp.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: actual=empty required=entry at %0t", $time);
      end else begin
        exp_r  = exp_rsp.pop_front();
        exp_rv = 1'b1;
      end
      m_drain++;
    end
    case (m_state)
      IDLE:      if (|req_valid) m_state = FILL;
      FILL:      if (old_issue == DEP) m_state = WAIT_FULL;
      WAIT_FULL: if (!RDY_mult) m_state = DRAIN;
      DRAIN: if (old_drain == DEP) begin
        m_state = IDLE;
        m_issue = 0;
        m_drain = 0;
      end
      default: m_state = IDLE;
    endcase
  endtask

  task automatic fill_to_full(input string nm);
    int n = 0;
    while (m_state != WAIT_FULL && n < 300) begin
      step();
      n++;
    end
    chk(nm, n < 300, 1'b1);
  endtask

  task automatic drain_to_idle(input string nm);
    int n = 0;
    while (!(m_state == IDLE && !exp_rv) && n < 400) begin
      step();
      if (m_state == IDLE) rdy_cfg = 1'b1;
      n++;
    end
    chk(nm, n < 400, 1'b1);
  endtask

  initial begin
    vec_t tbl [6];
    int   n;
    tbl[0] = '{rv: 2'b00, rdy: 1'b1, exp_ready: 2'b00};
    tbl[1] = '{rv: 2'b01, rdy: 1'b1, exp_ready: 2'b01};
    tbl[2] = '{rv: 2'b10, rdy: 1'b1, exp_ready: 2'b10};
    tbl[3] = '{rv: 2'b11, rdy: 1'b1, exp_ready: 2'b01};
    tbl[4] = '{rv: 2'b11, rdy: 1'b0, exp_ready: 2'b00};
    tbl[5] = '{rv: 2'b10, rdy: 1'b0, exp_ready: 2'b00};

    rst = 1'b1;
    req_valid = '0; req_op0 = '0; req_op1 = '0;
    RDY_mult = 1'b0; VALID_memVal = 1'b0; memVal_data = '0;
    src_en = '0; rdy_cfg = 1'b0; spur_en = 1'b0;
    model_reset();
    #12;
    chk("rst_EN_mult", EN_mult, 1'b0);
    chk("rst_mult_input0", mult_input0, 16'h0);
    chk("rst_mult_input1", mult_input1, 16'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_EN_blockRead", EN_blockRead, 1'b0);
    for (int i = 0; i < 6; i++) begin
      req_valid = tbl[i].rv;
      RDY_mult  = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].exp_ready);
    end
    req_valid = '0;
    RDY_mult  = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // single requester block, spurious beats outside DRAIN throughout
    for (int k = 0; k < DEP; k++) src_q[0].push_back({16'(k), 16'd2});
    src_en = 2'b01; rdy_cfg = 1'b1; spur_en = 1'b1;
    blk_pulses = 0; rsp_seen = 0;
    fill_to_full("t1_fill_bound");
    repeat (3) step();
    rdy_cfg = 1'b0;
    drain_to_idle("t1_drain_bound");
    repeat (2) step();
    chk("t1_blockRead_pulses", blk_pulses, 1);
    chk("t1_rsp_count", rsp_seen, DEP);

    // two requesters, held valid past the block boundary
    spur_en = 1'b0;
    for (int k = 0; k < 70; k++) begin
      src_q[0].push_back({16'h1000 + 16'(k), 16'd3});
      src_q[1].push_back({16'h2000 + 16'(k), 16'd5});
    end
    src_en = 2'b11; rdy_cfg = 1'b1;
    blk_pulses = 0; rsp_seen = 0;
    fill_to_full("t2_fill_bound");
    repeat (4) step();
    rdy_cfg = 1'b0;
    drain_to_idle("t2_drain_bound");
    chk("t2_blockRead_pulses", blk_pulses, 1);
    chk("t2_rsp_count", rsp_seen, DEP);

    // second block: multiplier stall at 20 issues, then reset mid-drain
    n = 0;
    while (m_issue < 20 && n < 100) begin
      step();
      n++;
    end
    chk("t3_reach20_bound", n < 100, 1'b1);
    rdy_cfg = 1'b0;
    repeat (5) step();
    rdy_cfg = 1'b1;
    fill_to_full("t3_fill_bound");
    rdy_cfg = 1'b0;
    n = 0;
    while (m_drain < 10 && n < 200) begin
      step();
      n++;
    end
    chk("t5_beat10_bound", n < 200, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_rsp_valid", rsp_valid, 1'b0);
    chk("t5_rst_EN_mult", EN_mult, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_mult_input0", mult_input0, 16'h0);
    chk("t5_rst_rsp_id", rsp_id, 3'h0);
    chk("t5_rst_rsp_data", rsp_data, 16'h0);
    src_en = '0; req_valid = '0; VALID_memVal = 1'b0; RDY_mult = 1'b0;
    #1;
    chk("t5_rst_EN_blockRead", EN_blockRead, 1'b0);
    chk("t5_rst_req_ready", req_ready, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    src_q[0].delete();
    src_q[1].delete();

    // spurious product beats while idle
    spur_en = 1'b1; rdy_cfg = 1'b1;
    repeat (6) step();
    spur_en = 1'b0;

    // fresh block from requester 1 only, starting at slot 0 after reset
    for (int k = 0; k < DEP; k++) src_q[1].push_back({16'(k + 100), 16'd7});
    src_en = 2'b10;
    blk_pulses = 0; rsp_seen = 0;
    fill_to_full("t7_fill_bound");
    rdy_cfg = 1'b0;
    drain_to_idle("t7_drain_bound");
    repeat (2) step();
    chk("t7_blockRead_pulses", blk_pulses, 1);
    chk("t7_rsp_count", rsp_seen, DEP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
